lsu: RTL and testbench

Parametrised load/store unit sitting between the register manager (issue side), the data memory port and the write-back stage. Accepts one memory operation at a time, computes the effective address, handles byte/half/word(/double when XLEN=64) accesses with lane alignment and sign/zero extension, and detects misaligned addresses. Supports a back-pressured memory request channel, error responses and pipeline flush with response draining. Returns a registered write-back record, optionally flagged as an exception.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_if.sv | 49 ++++
 rtl/lsu_align.sv | 54 +++++
 rtl/lsu.sv | 191 +++++++++++++++++++
 tb/tb_lsu.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, exception causes and
// controller states.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    CAUSE_LD_MIS   = 2'd0,
    CAUSE_ST_MIS   = 2'd1,
    CAUSE_LD_FAULT = 2'd2,
    CAUSE_ST_FAULT = 2'd3
  } cause_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WB    = 3'd4
  } state_e;

endpackage

// File: rtl/lsu_if.sv
// Issue, data-memory and write-back channels of the load/store unit.
// The slave modport is the unit's view; master is the surrounding pipeline/memory.
interface lsu_if #(
  parameter int XLEN = 32
) ();
  localparam int NB = XLEN / 8;

  logic            issue_v;
  logic            issue_ready;
  logic            op_store;
  logic [1:0]      op_size;
  logic            op_unsigned;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic [4:0]      rd_i;

  logic            mem_req_v;
  logic            mem_req_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_adr;
  logic [XLEN-1:0] mem_wdata;
  logic [NB-1:0]   mem_strobe;
  logic            mem_rsp_v;
  logic [XLEN-1:0] mem_rsp_data;
  logic            mem_rsp_err;

  logic            wb_v;
  logic            wb_ready;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      wb_rd;
  logic            wb_exc;
  logic [1:0]      wb_cause;

  modport slave (
    input  issue_v, op_store, op_size, op_unsigned, rs1, rs2, imm, rd_i,
    input  mem_req_ready, mem_rsp_v, mem_rsp_data, mem_rsp_err, wb_ready,
    output issue_ready, mem_req_v, mem_we, mem_adr, mem_wdata, mem_strobe,
    output wb_v, wb_data, wb_rd, wb_exc, wb_cause
  );

  modport master (
    output issue_v, op_store, op_size, op_unsigned, rs1, rs2, imm, rd_i,
    output mem_req_ready, mem_rsp_v, mem_rsp_data, mem_rsp_err, wb_ready,
    input  issue_ready, mem_req_v, mem_we, mem_adr, mem_wdata, mem_strobe,
    input  wb_v, wb_data, wb_rd, wb_exc, wb_cause
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store data shift and strobes,
// alignment check at issue, and load extract with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB  = XLEN / 8,
  localparam int OFS = $clog2(NB)
) (
  input  size_e           iss_size_i,
  input  logic [OFS-1:0]  iss_ofs_i,
  input  logic [XLEN-1:0] iss_data_i,
  output logic            iss_misaligned_o,
  output logic [XLEN-1:0] st_wdata_o,
  output logic [NB-1:0]   st_strobe_o,
  input  size_e           ld_size_i,
  input  logic            ld_unsigned_i,
  input  logic [OFS-1:0]  ld_ofs_i,
  input  logic [XLEN-1:0] ld_rsp_i,
  output logic [XLEN-1:0] ld_data_o
);

  logic [NB-1:0]   lane_mask;
  logic [OFS-1:0]  ofs_mask;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_mask;
  logic [XLEN-1:0] ld_top;
  int              ld_bits;

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < (1 << iss_size_i)) lane_mask[i] = 1'b1;
    end
    ofs_mask = OFS'((1 << iss_size_i) - 1);
    // A double on a 32-bit datapath can never be served in one beat.
    if (iss_size_i == SZ_D && XLEN == 32) iss_misaligned_o = 1'b1;
    else                                  iss_misaligned_o = |(iss_ofs_i & ofs_mask);
    st_strobe_o = lane_mask << iss_ofs_i;
    st_wdata_o  = iss_data_i << {iss_ofs_i, 3'b000};
  end

  always_comb begin
    ld_shift = ld_rsp_i >> {ld_ofs_i, 3'b000};
    ld_bits  = 8 << ld_size_i;
    if (ld_bits >= XLEN) ld_mask = '1;
    else                 ld_mask = (XLEN'(1) << ld_bits) - XLEN'(1);
    // Single-bit mask selecting the sign bit of the accessed field.
    ld_top = ld_mask ^ (ld_mask >> 1);
    if (!ld_unsigned_i && |(ld_shift & ld_top)) ld_data_o = ld_shift | ~ld_mask;
    else                                        ld_data_o = ld_shift & ld_mask;
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one memory operation at a time between issue, data memory
// and write-back, with misalignment/fault exceptions and flush draining.
//   state | meaning
//   IDLE  | ready for a new operation
//   REQ   | memory request presented, waiting for grant
//   WAIT  | request granted, waiting for response
//   DRAIN | flushed after grant, swallowing the orphan response
//   WB    | write-back record presented, waiting for wb_ready
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic  clk,
  input logic  rst,
  input logic  flush,
  lsu_if.slave bus
);

  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);

  state_e          state_q, state_d;
  logic [XLEN-1:0] adr_q, adr_d;
  logic            store_q, store_d;
  size_e           size_q, size_d;
  logic            uns_q, uns_d;
  logic [4:0]      rd_q, rd_d;

  logic            mem_req_v_q;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_adr_q, mem_adr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]   mem_strobe_q, mem_strobe_d;

  logic            wb_v_q;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_exc_q, wb_exc_d;
  cause_e          wb_cause_q, wb_cause_d;

  logic [XLEN-1:0] iss_adr;
  size_e           iss_size;
  logic            al_mis;
  logic [XLEN-1:0] al_wdata;
  logic [NB-1:0]   al_strobe;
  logic [XLEN-1:0] al_ld_data;

  assign iss_adr  = bus.rs1 + bus.imm;
  assign iss_size = size_e'(bus.op_size);

  lsu_align #(.XLEN(XLEN)) u_align (
    .iss_size_i       (iss_size),
    .iss_ofs_i        (iss_adr[OFS-1:0]),
    .iss_data_i       (bus.rs2),
    .iss_misaligned_o (al_mis),
    .st_wdata_o       (al_wdata),
    .st_strobe_o      (al_strobe),
    .ld_size_i        (size_q),
    .ld_unsigned_i    (uns_q),
    .ld_ofs_i         (adr_q[OFS-1:0]),
    .ld_rsp_i         (bus.mem_rsp_data),
    .ld_data_o        (al_ld_data)
  );

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    store_d      = store_q;
    size_d       = size_q;
    uns_d        = uns_q;
    rd_d         = rd_q;
    mem_we_d     = mem_we_q;
    mem_adr_d    = mem_adr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_strobe_d = mem_strobe_q;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    wb_exc_d     = wb_exc_q;
    wb_cause_d   = wb_cause_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.issue_v && !flush) begin
          adr_d   = iss_adr;
          store_d = bus.op_store;
          size_d  = iss_size;
          uns_d   = bus.op_unsigned;
          rd_d    = bus.rd_i;
          if (al_mis) begin
            state_d    = ST_WB;
            wb_exc_d   = 1'b1;
            wb_cause_d = bus.op_store ? CAUSE_ST_MIS : CAUSE_LD_MIS;
            wb_data_d  = iss_adr;
            wb_rd_d    = '0;
          end else begin
            state_d      = ST_REQ;
            mem_we_d     = bus.op_store;
            mem_adr_d    = iss_adr & ~XLEN'(NB - 1);
            mem_wdata_d  = al_wdata;
            mem_strobe_d = al_strobe;
          end
        end
      end
      ST_REQ: begin
        if (flush)                  state_d = ST_IDLE;
        else if (bus.mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rsp_v) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WB;
            if (bus.mem_rsp_err) begin
              wb_exc_d   = 1'b1;
              wb_cause_d = store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
              wb_data_d  = adr_q;
              wb_rd_d    = '0;
            end else begin
              wb_exc_d   = 1'b0;
              wb_cause_d = CAUSE_LD_MIS;
              wb_data_d  = store_q ? '0 : al_ld_data;
              wb_rd_d    = store_q ? 5'd0 : rd_q;
            end
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.mem_rsp_v) state_d = ST_IDLE;
      end
      ST_WB: begin
        if (flush || bus.wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      adr_q        <= '0;
      store_q      <= 1'b0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      rd_q         <= '0;
      mem_req_v_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_adr_q    <= '0;
      mem_wdata_q  <= '0;
      mem_strobe_q <= '0;
      wb_v_q       <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      wb_exc_q     <= 1'b0;
      wb_cause_q   <= CAUSE_LD_MIS;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      store_q      <= store_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      rd_q         <= rd_d;
      mem_req_v_q  <= (state_d == ST_REQ);
      mem_we_q     <= mem_we_d;
      mem_adr_q    <= mem_adr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_strobe_q <= mem_strobe_d;
      wb_v_q       <= (state_d == ST_WB);
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      wb_exc_q     <= wb_exc_d;
      wb_cause_q   <= wb_cause_d;
    end
  end

  assign bus.issue_ready = (state_q == ST_IDLE) && !rst && !flush;
  assign bus.mem_req_v   = mem_req_v_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_adr     = mem_adr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_strobe  = mem_strobe_q;
  assign bus.wb_v        = wb_v_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_exc      = wb_exc_q;
  assign bus.wb_cause    = wb_cause_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for the load/store unit: directed cases with literal expectations,
// then randomized operations checked against a transaction-level model.
module tb_lsu;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  lsu_if #(.XLEN(XLEN)) bus ();

  lsu #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected values published by the driver for the monitor.
  logic        req_ok = 1'b0;
  logic        wb_ok  = 1'b0;
  logic [31:0] exp_req_adr, exp_req_wdata;
  logic        exp_req_we;
  logic [3:0]  exp_req_strb;
  logic [31:0] exp_wb_data;
  logic [4:0]  exp_wb_rd;
  logic        exp_wb_exc;
  logic [1:0]  exp_wb_cause;

  // Observations of the last operation for directed literal checks.
  logic [31:0] last_req_adr, last_req_wdata, last_wb_data;
  logic        last_req_we, last_wb_exc;
  logic [3:0]  last_req_strb;
  logic [4:0]  last_wb_rd;
  logic [1:0]  last_wb_cause;
  int          last_lat;
  int          acc_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req_v) begin
        chk("req_allowed", bus.mem_req_v, req_ok);
        if (req_ok) begin
          chk("mem_adr", bus.mem_adr, exp_req_adr);
          chk("mem_we", bus.mem_we, exp_req_we);
          chk("mem_wdata", bus.mem_wdata, exp_req_wdata);
          chk("mem_strobe", bus.mem_strobe, exp_req_strb);
        end
      end
      if (bus.wb_v) begin
        chk("wb_allowed", bus.wb_v, wb_ok);
        if (wb_ok) begin
          chk("wb_data", bus.wb_data, exp_wb_data);
          chk("wb_rd", bus.wb_rd, exp_wb_rd);
          chk("wb_exc", bus.wb_exc, exp_wb_exc);
          if (exp_wb_exc) chk("wb_cause", bus.wb_cause, exp_wb_cause);
        end
      end
    end
  end

  // fmode: 0 none, 1 flush in REQ, 2 flush in WAIT before rsp, 3 flush with rsp, 4 flush in WB
  task automatic run_op(input bit st, input int sz, input bit uns,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [4:0] rd, input logic [31:0] rsp, input bit err,
                        input int req_wait, input int rsp_delay, input int wb_wait, input int fmode);
    logic [31:0] adr;
    logic [63:0] lim, v;
    int nb, off;
    bit mis;
    #1;
    chk("issue_ready_idle", bus.issue_ready, 1);
    adr = rs1 + imm;
    nb  = 1 << sz;
    off = int'(adr % 4);
    mis = (sz == 3) || (adr % nb != 0);
    exp_req_adr   = adr - off;
    exp_req_we    = st;
    exp_req_wdata = rs2 << (8 * off);
    exp_req_strb  = '0;
    for (int j = 0; j < 4; j++) if (j >= off && j < off + nb) exp_req_strb[j] = 1'b1;
    if (mis) begin
      exp_wb_exc = 1'b1; exp_wb_cause = st ? 2'd1 : 2'd0; exp_wb_data = adr; exp_wb_rd = 5'd0;
      if (fmode >= 1 && fmode <= 3) fmode = 0;
    end else if (err) begin
      exp_wb_exc = 1'b1; exp_wb_cause = st ? 2'd3 : 2'd2; exp_wb_data = adr; exp_wb_rd = 5'd0;
    end else begin
      lim = 64'd1 << (8 * nb);
      v   = ({32'd0, rsp} >> (8 * off)) % lim;
      if (!uns && v >= lim / 2) v = v - lim;
      exp_wb_exc  = 1'b0;
      exp_wb_data = st ? 32'd0 : v[31:0];
      exp_wb_rd   = st ? 5'd0 : rd;
    end
    if (fmode == 2 && rsp_delay == 0) rsp_delay = 1;

    bus.issue_v = 1'b1; bus.op_store = st; bus.op_size = 2'(sz); bus.op_unsigned = uns;
    bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm; bus.rd_i = rd;
    req_ok = !mis; wb_ok = mis;
    acc_cyc = cyc;
    tick();
    bus.issue_v = 1'b0;
    bus.rs1 = $urandom; bus.rs2 = $urandom; bus.imm = $urandom; bus.rd_i = 5'($urandom);
    bus.op_size = 2'($urandom); bus.op_store = 1'($urandom); bus.op_unsigned = 1'($urandom);

    if (!mis) begin
      for (int k = 0; k <= req_wait; k++) begin
        chk("req_v_held", bus.mem_req_v, 1);
        if (k == 0) begin
          last_req_adr = bus.mem_adr; last_req_we = bus.mem_we;
          last_req_wdata = bus.mem_wdata; last_req_strb = bus.mem_strobe;
        end
        bus.mem_req_ready = (k == req_wait) && (fmode != 1);
        flush             = (k == req_wait) && (fmode == 1);
        bus.mem_rsp_v     = 1'($urandom);
        bus.mem_rsp_data  = $urandom;
        bus.mem_rsp_err   = 1'($urandom);
        tick();
      end
      bus.mem_req_ready = 1'b0; flush = 1'b0; bus.mem_rsp_v = 1'b0; bus.mem_rsp_err = 1'b0;
      req_ok = 1'b0;
      chk("req_v_dropped", bus.mem_req_v, 0);
      if (fmode == 1) return;
      for (int k = 0; k < rsp_delay; k++) begin
        flush = (fmode == 2) && (k == 0);
        tick();
        flush = 1'b0;
      end
      bus.mem_rsp_v = 1'b1; bus.mem_rsp_data = rsp; bus.mem_rsp_err = err;
      flush = (fmode == 3);
      wb_ok = (fmode == 0) || (fmode == 4);
      tick();
      bus.mem_rsp_v = 1'b0; bus.mem_rsp_err = 1'b0; flush = 1'b0;
      if (fmode == 2 || fmode == 3) begin
        chk("no_wb_after_flush", bus.wb_v, 0);
        wb_ok = 1'b0;
        return;
      end
    end

    chk("wb_v_present", bus.wb_v, 1);
    last_lat = cyc - acc_cyc;
    last_wb_data = bus.wb_data; last_wb_rd = bus.wb_rd;
    last_wb_exc = bus.wb_exc; last_wb_cause = bus.wb_cause;
    for (int k = 0; k <= wb_wait; k++) begin
      if (k > 0) chk("wb_v_held", bus.wb_v, 1);
      bus.wb_ready = (k == wb_wait) && (fmode != 4);
      flush        = (k == wb_wait) && (fmode == 4);
      tick();
    end
    bus.wb_ready = 1'b0; flush = 1'b0; wb_ok = 1'b0;
    chk("wb_v_dropped", bus.wb_v, 0);
  endtask

  task automatic idle_gap();
    #1;
    bus.mem_rsp_v = 1'($urandom); bus.mem_rsp_data = $urandom; bus.mem_rsp_err = 1'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      bus.issue_v = 1'b1; flush = 1'b1;
      bus.rs1 = $urandom & ~32'h3; bus.imm = 32'd0; bus.op_size = 2'd2; bus.op_store = 1'($urandom);
    end
    tick();
    bus.issue_v = 1'b0; flush = 1'b0; bus.mem_rsp_v = 1'b0; bus.mem_rsp_err = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int sz, fm;
    bit st;
    logic [31:0] r1, im;
    rst = 1'b1; flush = 1'b0;
    bus.issue_v = 0; bus.op_store = 0; bus.op_size = 0; bus.op_unsigned = 0;
    bus.rs1 = 0; bus.rs2 = 0; bus.imm = 0; bus.rd_i = 0;
    bus.mem_req_ready = 0; bus.mem_rsp_v = 0; bus.mem_rsp_data = 0; bus.mem_rsp_err = 0;
    bus.wb_ready = 0;
    repeat (3) tick();
    chk("rst_issue_ready", bus.issue_ready, 0);
    chk("rst_mem_req_v", bus.mem_req_v, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_adr", bus.mem_adr, 0);
    chk("rst_mem_strobe", bus.mem_strobe, 0);
    chk("rst_wb_v", bus.wb_v, 0);
    chk("rst_wb_exc", bus.wb_exc, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    rst = 1'b0;
    tick();

    run_op(0, 2, 0, 32'h1000, 32'h0, 32'd4, 5'd7, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("lw_adr", last_req_adr, 32'h1004);
    chk("lw_data", last_wb_data, 32'hDEADBEEF);
    chk("lw_rd", last_wb_rd, 5'd7);
    chk("lw_latency", last_lat, 3);

    run_op(0, 0, 0, 32'h1000, 32'h0, 32'd3, 5'd3, 32'h80FFFFFF, 0, 0, 0, 0, 0);
    chk("lb_signed", last_wb_data, 32'hFFFFFF80);
    run_op(0, 0, 1, 32'h1000, 32'h0, 32'd3, 5'd3, 32'h80FFFFFF, 0, 1, 1, 1, 0);
    chk("lbu", last_wb_data, 32'h00000080);

    run_op(1, 1, 0, 32'h2000, 32'h1234, 32'd2, 5'd9, 32'h0, 0, 0, 0, 0, 0);
    chk("sh_strobe", last_req_strb, 4'b1100);
    chk("sh_wdata", last_req_wdata, 32'h12340000);
    chk("sh_we", last_req_we, 1);
    chk("sh_rd", last_wb_rd, 5'd0);

    run_op(0, 2, 0, 32'h1000, 32'h0, 32'd1, 5'd4, 32'h0, 0, 0, 0, 0, 0);
    chk("mis_exc", last_wb_exc, 1);
    chk("mis_cause", last_wb_cause, 2'd0);
    chk("mis_data", last_wb_data, 32'h1001);
    chk("mis_latency", last_lat, 1);

    run_op(1, 2, 0, 32'h4000, 32'hCAFEF00D, 32'd8, 5'd5, 32'h0, 1, 5, 1, 2, 0);
    chk("st_fault_cause", last_wb_cause, 2'd3);
    chk("st_fault_data", last_wb_data, 32'h4008);

    run_op(0, 2, 0, 32'h5000, 32'h0, 32'd0, 5'd6, 32'h11111111, 0, 0, 2, 0, 2);
    run_op(0, 1, 0, 32'h5000, 32'h0, 32'd2, 5'd6, 32'h80017FFF, 0, 0, 0, 0, 0);
    chk("lh_after_drain", last_wb_data, 32'hFFFF8001);

    // Reset while waiting for a response.
    #1;
    bus.issue_v = 1'b1; bus.op_store = 1'b1; bus.op_size = 2'd2; bus.op_unsigned = 1'b0;
    bus.rs1 = 32'h3000; bus.imm = 32'd0; bus.rs2 = 32'h55; bus.rd_i = 5'd1;
    exp_req_adr = 32'h3000; exp_req_we = 1'b1; exp_req_wdata = 32'h55; exp_req_strb = 4'hF;
    req_ok = 1'b1;
    tick();
    bus.issue_v = 1'b0; bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0; req_ok = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_mem_adr", bus.mem_adr, 0);
    chk("midrst_mem_we", bus.mem_we, 0);
    chk("midrst_wb_v", bus.wb_v, 0);
    run_op(0, 2, 1, 32'h3000, 32'h0, 32'd0, 5'd2, 32'h76543210, 0, 0, 0, 0, 0);
    chk("midrst_next_load", last_wb_data, 32'h76543210);

    for (int n = 0; n < 250; n++) begin
      st = 1'($urandom);
      sz = $urandom_range(0, 3);
      r1 = $urandom;
      im = $urandom;
      if ($urandom_range(0, 3) != 0) im = im - ((r1 + im) % (32'd1 << sz));
      fm = $urandom_range(0, 9);
      fm = (fm <= 5) ? 0 : fm - 5;
      run_op(st, sz, 1'($urandom), r1, $urandom, im, 5'($urandom), $urandom,
             ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2), fm);
      if ($urandom_range(0, 2) == 0) idle_gap();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
